question_link_rx: RTL and testbench

//  Receives one factorization question from the partner board over the GPIO link.
//  The link is a 4-bit NUM bus plus an OK strobe, both asynchronous to CLK.

---
 rtl/question_link_rx.sv | 191 +++++++++++++++++++
 tb/tb_question_link_rx.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/question_link_rx.sv
// question_link_rx: assembles one factorization question from the partner board's
// asynchronous 4-bit NUM / OK strobe link into a QUESTION word (first nibble in the MSBs),
// guarded by an inter-nibble timeout and handed off with a Q_VALID/Q_ACK handshake.
//
// Latency: OK_IN rise -> nibble captured at the 3rd CLK edge; the final nibble's rise
// raises Q_VALID after the same 3rd edge.
// Backpressure: none on the link side. A frame that completes while Q_VALID is still
// pending overwrites QUESTION and pulses ERR (overrun).
//
// Ports:
//   CLK, RST        system clock, asynchronous active-high reset
//   OK_IN, NUM_IN   asynchronous link strobe and nibble bus
//   Q_ACK           consumer acknowledge, clears Q_VALID
//   QUESTION        last complete frame
//   Q_VALID         frame pending level
//   BUSY            frame partially received
//   ERR             1-cycle pulse on timeout, overrun or checksum error
//
// Optional feature macro: QLINK_CHECKSUM_EN -- each frame carries a trailing nibble that
// must equal the XOR of its data nibbles; mismatching frames are dropped with ERR.
module question_link_rx #(
  parameter int NIBBLES = 6,
  parameter int TIMEOUT = 50_000_000
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   OK_IN,
  input  logic [3:0]             NUM_IN,
  input  logic                   Q_ACK,
  output logic [4*NIBBLES-1:0]   QUESTION,
  output logic                   Q_VALID,
  output logic                   BUSY,
  output logic                   ERR
);

  localparam int W     = 4 * NIBBLES;
  localparam int IDX_W = $clog2(NIBBLES + 1);
  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
`ifdef QLINK_CHECKSUM_EN
  localparam int FRAME_LEN = NIBBLES + 1;
`else
  localparam int FRAME_LEN = NIBBLES;
`endif
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  typedef enum logic {
    S_IDLE,
    S_RECV
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  // Two-flop synchronizers; r_ok_d is the extra delay stage for edge detection.
  logic             r_ok_s1;
  logic             r_ok_s;
  logic             r_ok_d;
  logic [3:0]       r_num_s1;
  logic [3:0]       r_num_s;

  logic [W-1:0]     r_shift;
  logic [IDX_W-1:0] r_idx;
  logic [TMR_W-1:0] r_timer;
  logic [W-1:0]     r_question;
  logic             r_q_valid;
  logic             r_err;
`ifdef QLINK_CHECKSUM_EN
  logic [3:0]       r_csum;
`endif

  logic             w_edge;
  logic             w_data_edge;
  logic             w_frame_done;
  logic             w_commit;
  logic             w_bad;
  logic             w_timeout;
  logic [W-1:0]     w_shift_in;
  logic [W-1:0]     w_word;

  assign w_edge     = r_ok_s & ~r_ok_d;
  assign w_shift_in = (r_shift << 4) | W'(r_num_s);

`ifdef QLINK_CHECKSUM_EN
  // The trailer nibble is checked, never shifted into the data word.
  assign w_data_edge = w_edge & ~((r_state == S_RECV) && (r_idx == LAST_IDX));
  assign w_word      = r_shift;
`else
  assign w_data_edge = w_edge;
  assign w_word      = w_shift_in;
`endif

  always_comb begin
    w_state_nxt  = r_state;
    w_frame_done = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_edge) begin
          if (FRAME_LEN == 1) w_frame_done = 1'b1;
          else                w_state_nxt  = S_RECV;
        end
      end
      S_RECV: begin
        // An edge in the timeout cycle wins: the nibble is taken, the timer restarts.
        if (w_edge) begin
          if (r_idx == LAST_IDX) begin
            w_frame_done = 1'b1;
            w_state_nxt  = S_IDLE;
          end
        end else if (r_timer == TMR_LAST) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

`ifdef QLINK_CHECKSUM_EN
  assign w_commit = w_frame_done & (r_num_s == r_csum);
  assign w_bad    = w_frame_done & (r_num_s != r_csum);
`else
  assign w_commit = w_frame_done;
  assign w_bad    = 1'b0;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_ok_s1    <= 1'b0;
      r_ok_s     <= 1'b0;
      r_ok_d     <= 1'b0;
      r_num_s1   <= 4'h0;
      r_num_s    <= 4'h0;
      r_state    <= S_IDLE;
      r_shift    <= '0;
      r_idx      <= '0;
      r_timer    <= '0;
      r_question <= '0;
      r_q_valid  <= 1'b0;
      r_err      <= 1'b0;
`ifdef QLINK_CHECKSUM_EN
      r_csum     <= 4'h0;
`endif
    end else begin
      r_ok_s1  <= OK_IN;
      r_ok_s   <= r_ok_s1;
      r_ok_d   <= r_ok_s;
      r_num_s1 <= NUM_IN;
      r_num_s  <= r_num_s1;
      r_state  <= w_state_nxt;

      // Overrun only when the pending frame is not being acked in the same cycle.
      r_err <= w_timeout | w_bad | (w_commit & r_q_valid & ~Q_ACK);

      if (w_commit) begin
        r_question <= w_word;
        r_q_valid  <= 1'b1;
      end else if (Q_ACK) begin
        r_q_valid  <= 1'b0;
      end

      if (w_edge) begin
        r_timer <= '0;
        if (r_state == S_IDLE) begin
          r_shift <= W'(r_num_s);
          r_idx   <= IDX_W'(1);
`ifdef QLINK_CHECKSUM_EN
          r_csum  <= r_num_s;
`endif
        end else begin
          r_idx <= r_idx + IDX_W'(1);
          if (w_data_edge) begin
            r_shift <= w_shift_in;
`ifdef QLINK_CHECKSUM_EN
            r_csum  <= r_csum ^ r_num_s;
`endif
          end
        end
      end else if (r_state == S_RECV) begin
        r_timer <= w_timeout ? '0 : r_timer + TMR_W'(1);
      end
    end
  end

  assign QUESTION = r_question;
  assign Q_VALID  = r_q_valid;
  assign BUSY     = (r_state == S_RECV);
  assign ERR      = r_err;

endmodule

// File: tb/tb_question_link_rx.sv
// Testbench for question_link_rx (NIBBLES=6, TIMEOUT=20): directed scenarios followed by
// randomized frames, checked against a frame-level model (expected word, pending flag,
// expected ERR pulse count).
module tb_question_link_rx;

  localparam int NIB = 6;
  localparam int TMO = 20;

  logic        CLK = 1'b0;
  logic        RST;
  logic        OK_IN;
  logic [3:0]  NUM_IN;
  logic        Q_ACK;
  logic [23:0] QUESTION;
  logic        Q_VALID;
  logic        BUSY;
  logic        ERR;

  int checks   = 0;
  int failures = 0;
  int err_cnt  = 0;
  int exp_err  = 0;
  logic [23:0] exp_q;
  logic        exp_v;

  question_link_rx #(.NIBBLES(NIB), .TIMEOUT(TMO)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .OK_IN    (OK_IN),
    .NUM_IN   (NUM_IN),
    .Q_ACK    (Q_ACK),
    .QUESTION (QUESTION),
    .Q_VALID  (Q_VALID),
    .BUSY     (BUSY),
    .ERR      (ERR)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) if (ERR === 1'b1) err_cnt++;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One OK pulse carrying nibble n. For the frame's final nibble the completion is
  // checked at the 3rd edge after the rise (optionally with Q_ACK in that same cycle).
  task automatic send_nibble(input logic [3:0] n, input int pulse, input int gap,
                             input bit last, input bit ack_done, input logic [23:0] word);
    logic prev_v;
    bit   ovr;
    prev_v = exp_v;
    ovr    = exp_v && !ack_done;
    NUM_IN = n;
    OK_IN  = 1'b1;
    for (int i = 0; i < pulse + gap; i++) begin
      if (i == pulse) OK_IN = 1'b0;
      if (last && ack_done && i == 2) Q_ACK = 1'b1;
      step();
      if (last && i == 1) check("valid_before_3rd_edge", Q_VALID, prev_v);
      if (last && i == 2) begin
        Q_ACK = 1'b0;
        check("valid_at_3rd_edge", Q_VALID, 1);
        check("question", QUESTION, word);
        check("err_overrun", ERR, ovr);
        check("busy_done", BUSY, 0);
        exp_q = word;
        exp_v = 1'b1;
        if (ovr) exp_err++;
      end
    end
  endtask

  task automatic send_frame(input logic [23:0] word, input int pulse, input int gap,
                            input bit ack_done);
    logic [3:0] x;
    x = 4'h0;
    for (int k = 0; k < NIB; k++) begin
      logic [3:0] n;
      n = word[4*(NIB-1-k) +: 4];
      x ^= n;
`ifdef QLINK_CHECKSUM_EN
      send_nibble(n, pulse, gap, 1'b0, 1'b0, word);
`else
      send_nibble(n, pulse, gap, k == NIB - 1, ack_done, word);
`endif
    end
`ifdef QLINK_CHECKSUM_EN
    send_nibble(x, pulse, gap, 1'b1, ack_done, word);
`endif
    step();
    check("err_total", err_cnt, exp_err);
    check("busy_idle", BUSY, 0);
  endtask

  task automatic ack_pulse();
    Q_ACK = 1'b1;
    step();
    Q_ACK = 1'b0;
    exp_v = 1'b0;
    check("ack_clears_valid", Q_VALID, 0);
  endtask

  initial begin
    RST    = 1'b1;
    OK_IN  = 1'b0;
    NUM_IN = 4'h0;
    Q_ACK  = 1'b0;
    exp_q  = 24'h0;
    exp_v  = 1'b0;
    repeat (3) step();
    check("rst_question", QUESTION, 0);
    check("rst_valid", Q_VALID, 0);
    check("rst_busy", BUSY, 0);
    check("rst_err", ERR, 0);
    RST = 1'b0;
    repeat (2) step();

    // Normal frame, 10-cycle pulses and gaps (nibble edges land on the timeout cycle).
    send_frame(24'h123456, 10, 10, 1'b0);

    // Handshake: Q_VALID holds without ACK, drops the cycle after ACK.
    for (int i = 0; i < 100; i++) begin
      step();
      check("valid_hold", Q_VALID, 1);
    end
    ack_pulse();
    check("question_hold", QUESTION, 24'h123456);

    // ACK while nothing is pending is ignored.
    ack_pulse();
    check("question_after_idle_ack", QUESTION, 24'h123456);

    // Timeout after three nibbles.
    send_nibble(4'hA, 10, 10, 1'b0, 1'b0, 24'h0);
    send_nibble(4'hB, 10, 10, 1'b0, 1'b0, 24'h0);
    send_nibble(4'hC, 10, 10, 1'b0, 1'b0, 24'h0);
    check("busy_partial", BUSY, 1);
    check("no_early_timeout", err_cnt, exp_err);
    repeat (25) step();
    exp_err++;
    check("timeout_err", err_cnt, exp_err);
    check("timeout_busy", BUSY, 0);
    check("timeout_question", QUESTION, exp_q);
    check("timeout_valid", Q_VALID, 0);
    send_frame(24'h987654, 10, 10, 1'b0);
    ack_pulse();

    // Overrun: second frame with no ACK.
    send_frame(24'h123456, 10, 10, 1'b0);
    send_frame(24'hFEDCBA, 10, 10, 1'b0);
    check("overrun_valid", Q_VALID, 1);
    check("overrun_question", QUESTION, 24'hFEDCBA);

    // Completion with ACK in the same cycle: loaded, stays valid, no ERR.
    send_frame(24'h0A5F3C, 4, 4, 1'b1);
    check("ack_same_cycle_valid", Q_VALID, 1);

    // OK held high across many cycles captures only once per pulse.
    ack_pulse();
    send_frame(24'h3C5A96, 15, 3, 1'b0);

    // Reset mid-frame while a frame is pending.
    send_nibble(4'h7, 5, 5, 1'b0, 1'b0, 24'h0);
    send_nibble(4'h8, 5, 5, 1'b0, 1'b0, 24'h0);
    check("busy_before_rst", BUSY, 1);
    RST = 1'b1;
    #1;
    check("midrst_question", QUESTION, 0);
    check("midrst_valid", Q_VALID, 0);
    check("midrst_busy", BUSY, 0);
    check("midrst_err", ERR, 0);
    repeat (3) step();
    RST   = 1'b0;
    exp_q = 24'h0;
    exp_v = 1'b0;
    step();
    send_frame(24'h000015, 10, 10, 1'b0);

    // Randomized frames, timing and acknowledge policy.
    for (int f = 0; f < 20; f++) begin
      logic [23:0] w;
      int          pol;
      w   = 24'($urandom);
      pol = $urandom_range(0, 2);
      if (pol == 0) ack_pulse();
      send_frame(w, $urandom_range(1, 6), $urandom_range(3, 8), pol == 1);
    end

`ifdef QLINK_CHECKSUM_EN
    // Bad trailer: frame dropped with ERR, nothing delivered.
    ack_pulse();
    begin
      logic [23:0] prev_q;
      prev_q = QUESTION;
      for (int k = 0; k < NIB; k++)
        send_nibble(4'(k + 1), 10, 10, 1'b0, 1'b0, 24'h0);
      send_nibble(4'h0, 10, 10, 1'b0, 1'b0, 24'h0);
      step();
      exp_err++;
      check("csum_err", err_cnt, exp_err);
      check("csum_valid", Q_VALID, 0);
      check("csum_question", QUESTION, prev_q);
      check("csum_busy", BUSY, 0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
